bus_slave_sel: RTL and testbench

Parametrised, registered bus slave selector with per-transaction tracking for the AZ-Processor bus. Replaces the purely combinational 8-way index decoder. It latches the slave index from the upper address bits on address strobe and holds the active-low chip select for the whole access. It routes the selected slave's ready back to the granted master and reports unmapped or hung accesses with a bus-error pulse. Sits between the bus arbiter's master-side multiplexer and the slave-side chip-select/ready fabric.

---
 rtl/bus_slave_sel.sv | 166 ++++++++++++++++
 tb/tb_bus_slave_sel.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_slave_sel.sv
// bus_slave_sel: registered slave selector for the AZ-Processor bus.
//
// Latches the slave index from the top IDX_W bits of m_addr on address strobe,
// holds the active-low chip select for the whole access, routes the selected
// slave's ready back to the master and pulses err on unmapped (or, optionally,
// hung) accesses.
//
// Optional feature macro: BUS_SLAVE_TIMEOUT_EN
//   defined     - an ACCESS that sees no ready for TIMEOUT cycles ends in ERR.
//   not defined - no counter is built; ACCESS waits for ready indefinitely and
//                 TIMEOUT/TMO_W are unused.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset_   in   synchronous reset, active low
//   m_as_    in   address strobe from the granted master, active low
//   m_addr   in   word address from the granted master
//   s_rdy_   in   per-slave ready, active low
//   s_cs_    out  registered chip selects, active low, at most one low
//   s_index  out  latched index of the current or last access
//   busy     out  high while in ACCESS or ERR
//   rdy_     out  ready to master, active low
//   err      out  one-cycle bus-error pulse
module bus_slave_sel #(
  parameter int unsigned ADDR_W  = 30,
  parameter int unsigned N_SLAVE = 8,
  parameter int unsigned IDX_W   = 3,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TMO_W   = 8
) (
  input  logic               clk,
  input  logic               reset_,
  input  logic               m_as_,
  input  logic [ADDR_W-1:0]  m_addr,
  input  logic [N_SLAVE-1:0] s_rdy_,
  output logic [N_SLAVE-1:0] s_cs_,
  output logic [IDX_W-1:0]   s_index,
  output logic               busy,
  output logic               rdy_,
  output logic               err
);

  localparam int unsigned IdxLimW = IDX_W + 1;
  // One extra bit so N_SLAVE == 2**IDX_W is representable; then every index maps.
  localparam logic [IdxLimW-1:0] NSlaveLim = IdxLimW'(N_SLAVE);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StErr
  } state_e;

  state_e             state_q;
  logic [N_SLAVE-1:0] cs_q;
  logic [IDX_W-1:0]   idx_q;

  logic [IDX_W-1:0]   addr_idx;
  logic               addr_mapped;
  logic [N_SLAVE-1:0] cs_dec;
  logic               sel_rdy_n;
  logic               tmo_hit;

  assign addr_idx    = m_addr[ADDR_W-1 -: IDX_W];
  assign addr_mapped = ({1'b0, addr_idx} < NSlaveLim);

  // Only the upper index bits select a slave; the word offset is not decoded here.
  logic unused_addr_low;
  assign unused_addr_low = ^m_addr[ADDR_W-IDX_W-1:0];

  // One-hot active-low decode of the incoming index.
  always_comb begin
    cs_dec = '1;
    for (int unsigned i = 0; i < N_SLAVE; i++) begin
      if (addr_idx == i[IDX_W-1:0]) begin
        cs_dec[i] = 1'b0;
      end
    end
  end

  // Ready of the latched slave only; other slaves' ready lines are ignored.
  always_comb begin
    sel_rdy_n = 1'b1;
    for (int unsigned i = 0; i < N_SLAVE; i++) begin
      if (idx_q == i[IDX_W-1:0]) begin
        sel_rdy_n = s_rdy_[i];
      end
    end
  end

`ifdef BUS_SLAVE_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_q;

  assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT - 1));

  // Held at zero outside ACCESS, so every access starts counting from 0.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      tmo_cnt_q <= '0;
    end else if (state_q != StAccess) begin
      tmo_cnt_q <= '0;
    end else if (sel_rdy_n && !tmo_hit) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end
`else
  localparam int unsigned unused_tmo_cfg = TIMEOUT + TMO_W;

  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q <= StIdle;
      cs_q    <= '1;
      idx_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!m_as_) begin
            idx_q <= addr_idx;
            if (addr_mapped) begin
              cs_q    <= cs_dec;
              state_q <= StAccess;
            end else begin
              state_q <= StErr;
            end
          end
        end
        StAccess: begin
          // Ready wins over timeout when both occur in the same cycle.
          if (!sel_rdy_n) begin
            cs_q    <= '1;
            state_q <= StIdle;
          end else if (tmo_hit) begin
            cs_q    <= '1;
            state_q <= StErr;
          end
        end
        StErr: begin
          state_q <= StIdle;
        end
        default: begin
          cs_q    <= '1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Status outputs decode the state register directly, so they cannot glitch
  // on input changes; rdy_ in ACCESS is an intentional pass-through.
  always_comb begin
    rdy_ = 1'b1;
    unique case (state_q)
      StAccess: rdy_ = sel_rdy_n;
      StErr:    rdy_ = 1'b0;
      default:  rdy_ = 1'b1;
    endcase
  end

  assign busy    = (state_q != StIdle);
  assign err     = (state_q == StErr);
  assign s_cs_   = cs_q;
  assign s_index = idx_q;

endmodule

// File: tb/tb_bus_slave_sel.sv
module tb_bus_slave_sel;

  localparam int unsigned AW = 30;
  localparam int unsigned NS = 6;
  localparam int unsigned IW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_;
  logic          m_as_;
  logic [AW-1:0] m_addr;
  logic [NS-1:0] s_rdy_;
  logic [NS-1:0] s_cs_;
  logic [IW-1:0] s_index;
  logic          busy;
  logic          rdy_;
  logic          err;

  // Second instance with N_SLAVE == 2**IDX_W: every index is mapped.
  logic [7:0]    f_rdy_;
  logic [7:0]    f_cs_;
  logic [2:0]    f_index;
  logic          f_busy;
  logic          f_rdy_o;
  logic          f_err;

  bus_slave_sel #(
    .ADDR_W (AW),
    .N_SLAVE(NS),
    .IDX_W  (IW),
    .TIMEOUT(4),
    .TMO_W  (2)
  ) u_dut (
    .clk    (clk),
    .reset_ (reset_),
    .m_as_  (m_as_),
    .m_addr (m_addr),
    .s_rdy_ (s_rdy_),
    .s_cs_  (s_cs_),
    .s_index(s_index),
    .busy   (busy),
    .rdy_   (rdy_),
    .err    (err)
  );

  bus_slave_sel u_full (
    .clk    (clk),
    .reset_ (reset_),
    .m_as_  (m_as_),
    .m_addr (m_addr),
    .s_rdy_ (f_rdy_),
    .s_cs_  (f_cs_),
    .s_index(f_index),
    .busy   (f_busy),
    .rdy_   (f_rdy_o),
    .err    (f_err)
  );

  typedef struct packed {
    logic [NS-1:0] cs;
    logic [IW-1:0] idx;
    logic          busy;
    logic          rdy;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Advance to just after the next rising edge; inputs set afterwards belong to
  // the new cycle and are sampled at the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the expected outputs for this cycle, then compare on the falling edge.
  task automatic chk(input string tag, input logic [NS-1:0] cs, input logic [IW-1:0] idx,
                     input logic b, input logic r, input logic e);
    exp_t ex;
    exp_t got;
    ex.cs   = cs;
    ex.idx  = idx;
    ex.busy = b;
    ex.rdy  = r;
    ex.err  = e;
    exp_q.push_back(ex);
    @(negedge clk);
    got = exp_q.pop_front();
    cmp({tag, ".cs"},   {2'b00, s_cs_},     {2'b00, got.cs});
    cmp({tag, ".idx"},  {5'b0, s_index},    {5'b0, got.idx});
    cmp({tag, ".busy"}, {7'b0, busy},       {7'b0, got.busy});
    cmp({tag, ".rdy"},  {7'b0, rdy_},       {7'b0, got.rdy});
    cmp({tag, ".err"},  {7'b0, err},        {7'b0, got.err});
  endtask

  task automatic strobe(input logic [IW-1:0] idx);
    m_as_  = 1'b0;
    m_addr = {idx, 27'($urandom)};
  endtask

  initial begin
    reset_ = 1'b0;
    m_as_  = 1'b1;
    m_addr = '0;
    s_rdy_ = '1;
    f_rdy_ = 8'h00;

    // Reset held for two edges.
    tick();
    tick();
    chk("reset", 6'h3F, 3'd0, 1'b0, 1'b1, 1'b0);
    cmp("full_reset.cs", f_cs_, 8'hFF);
    cmp("full_reset.busy", {7'b0, f_busy}, 8'h00);

    // Mapped access to slave 5, ready in the third ACCESS cycle; slave 0's
    // ready is low meanwhile and must be ignored.
    reset_ = 1'b1;
    strobe(3'd5);
    tick();
    m_as_  = 1'b1;
    s_rdy_ = 6'b111110;
    chk("s5_c1", 6'h1F, 3'd5, 1'b1, 1'b1, 1'b0);
    tick();
    chk("s5_c2", 6'h1F, 3'd5, 1'b1, 1'b1, 1'b0);
    tick();
    s_rdy_ = 6'b011110;
    chk("s5_c3", 6'h1F, 3'd5, 1'b1, 1'b0, 1'b0);
    tick();
    s_rdy_ = '1;
    // Back-to-back: strobe in the IDLE cycle after completion.
    strobe(3'd1);
    chk("s5_done", 6'h3F, 3'd5, 1'b0, 1'b1, 1'b0);

    // Fastest access: ready in the first ACCESS cycle.
    tick();
    m_as_  = 1'b1;
    s_rdy_ = 6'b111101;
    chk("s1_c1", 6'h3D, 3'd1, 1'b1, 1'b0, 1'b0);
    tick();
    s_rdy_ = '1;
    strobe(3'd7);
    chk("s1_done", 6'h3F, 3'd1, 1'b0, 1'b1, 1'b0);

    // Unmapped index 7: ERR immediately; strobe during ERR must be ignored.
    tick();
    strobe(3'd2);
    chk("unmap7_err", 6'h3F, 3'd7, 1'b1, 1'b0, 1'b1);
    cmp("full_idx7.cs", f_cs_, 8'h7F);
    cmp("full_idx7.err", {7'b0, f_err}, 8'h00);
    cmp("full_idx7.rdy", {7'b0, f_rdy_o}, 8'h00);
    tick();
    m_as_ = 1'b1;
    chk("unmap7_idle", 6'h3F, 3'd7, 1'b0, 1'b1, 1'b0);
    cmp("full_idx7_done.cs", f_cs_, 8'hFF);

    // Unmapped boundary index 6 (== N_SLAVE).
    strobe(3'd6);
    tick();
    m_as_ = 1'b1;
    chk("unmap6_err", 6'h3F, 3'd6, 1'b1, 1'b0, 1'b1);
    tick();
    chk("unmap6_idle", 6'h3F, 3'd6, 1'b0, 1'b1, 1'b0);

    // Ready arriving in ACCESS cycle 4 (same cycle the timeout would fire).
    strobe(3'd2);
    tick();
    m_as_ = 1'b1;
    chk("race_c1", 6'h3B, 3'd2, 1'b1, 1'b1, 1'b0);
    tick();
    chk("race_c2", 6'h3B, 3'd2, 1'b1, 1'b1, 1'b0);
    tick();
    chk("race_c3", 6'h3B, 3'd2, 1'b1, 1'b1, 1'b0);
    tick();
    s_rdy_ = 6'b111011;
    chk("race_c4", 6'h3B, 3'd2, 1'b1, 1'b0, 1'b0);
    tick();
    s_rdy_ = '1;
    chk("race_done", 6'h3F, 3'd2, 1'b0, 1'b1, 1'b0);
    tick();
    chk("race_idle", 6'h3F, 3'd2, 1'b0, 1'b1, 1'b0);

    // Slave 2 never ready.
    strobe(3'd2);
    tick();
    m_as_ = 1'b1;
    chk("tmo_c1", 6'h3B, 3'd2, 1'b1, 1'b1, 1'b0);
    tick();
    chk("tmo_c2", 6'h3B, 3'd2, 1'b1, 1'b1, 1'b0);
    tick();
    chk("tmo_c3", 6'h3B, 3'd2, 1'b1, 1'b1, 1'b0);
    tick();
    chk("tmo_c4", 6'h3B, 3'd2, 1'b1, 1'b1, 1'b0);
`ifdef BUS_SLAVE_TIMEOUT_EN
    tick();
    chk("tmo_err", 6'h3F, 3'd2, 1'b1, 1'b0, 1'b1);
    tick();
    chk("tmo_idle", 6'h3F, 3'd2, 1'b0, 1'b1, 1'b0);
`else
    for (int i = 0; i < 300; i++) begin
      tick();
      chk("notmo_wait", 6'h3B, 3'd2, 1'b1, 1'b1, 1'b0);
    end
    // Only reset can release a hung access in this build.
    reset_ = 1'b0;
    tick();
    reset_ = 1'b1;
    chk("notmo_reset", 6'h3F, 3'd0, 1'b0, 1'b1, 1'b0);
`endif

    // Reset during the second ACCESS cycle, then a normal access.
    strobe(3'd4);
    tick();
    m_as_ = 1'b1;
    chk("rst_c1", 6'h2F, 3'd4, 1'b1, 1'b1, 1'b0);
    tick();
    reset_ = 1'b0;
    chk("rst_c2", 6'h2F, 3'd4, 1'b1, 1'b1, 1'b0);
    tick();
    reset_ = 1'b1;
    strobe(3'd3);
    chk("rst_after", 6'h3F, 3'd0, 1'b0, 1'b1, 1'b0);
    tick();
    m_as_  = 1'b1;
    s_rdy_ = 6'b110111;
    chk("post_rst_c1", 6'h37, 3'd3, 1'b1, 1'b0, 1'b0);
    tick();
    s_rdy_ = '1;
    chk("post_rst_done", 6'h3F, 3'd3, 1'b0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
